// File: rtl/router_pkg.sv
// Shared defaults and helpers for the router output-side synchroniser.
//   DefNumCh  - default number of output channels/FIFOs
//   DefAddrW  - default width of the header address field
//   DefCntW   - default width of the per-channel timeout counter
//   addr_bits - smallest address width able to name every channel
package router_pkg;

  localparam int unsigned DefNumCh = 3;
  localparam int unsigned DefAddrW = 2;
  localparam int unsigned DefCntW  = 5;

  // Smallest w with 2**w >= n (at least 1).
  function automatic int unsigned addr_bits(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// One channel's unread-data timeout: idle counter, one-cycle soft reset pulse
// and sticky status bit.
//   clk, resetn  - clock, asynchronous active-low reset
//   vld          - channel FIFO holds data
//   rd           - channel FIFO is being read this cycle
//   cfg          - idle cycles before a soft reset; 0 disables the timeout
//   clr          - clears the sticky status (a coincident set wins)
//   soft_reset   - registered one-cycle flush pulse
//   sts          - sticky: this channel has issued a soft reset
module router_sync_timer
  import router_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             vld,
  input  logic             rd,
  input  logic [CNT_W-1:0] cfg,
  input  logic             clr,
  output logic             soft_reset,
  output logic             sts
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             sts_q, sts_d;
  logic             idle;

  assign idle = vld & ~rd;

  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (cfg == '0) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (pulse_q) begin
      // Counting is held off for the pulse cycle, so a still-stuck FIFO
      // re-fires after cfg+1 cycles.
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (idle && (cnt_q >= (cfg - CNT_W'(1)))) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
    end else if (idle) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_comb begin
    sts_d = sts_q;
    if (pulse_d && !pulse_q) begin
      sts_d = 1'b1;
    end else if (clr) begin
      sts_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      sts_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      sts_q   <= sts_d;
    end
  end

  assign soft_reset = pulse_q;
  assign sts        = sts_q;

endmodule

// File: rtl/router_sync_n.sv
// Address/flow-control synchroniser between the router input FSM and NUM_CH
// output FIFOs. Latches the header address, steers the write enable to one
// FIFO, muxes back that FIFO's full flag, reports per-channel valid and
// flushes FIFOs whose data sits unread too long.
//   clk, resetn    - clock, asynchronous active-low reset
//   detect_add     - header present; latch data_in as the destination
//   data_in        - destination address field
//   write_enb_reg  - write request from the router FSM
//   full, empty    - per-FIFO status
//   read_enb       - per-FIFO read enable from the output side
//   timeout_cfg    - idle cycles before soft reset; 0 disables
//   sts_clr        - clears timeout_sts
//   fifo_full      - full flag of the addressed FIFO (0 if address invalid)
//   write_enb      - one-hot decoded write enable
//   vld_out        - per-channel data valid
//   soft_reset     - per-channel one-cycle flush pulse
//   addr_err       - latched address is out of range
//   timeout_sts    - per-channel sticky soft-reset status
module router_sync_n
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [CNT_W-1:0]  timeout_cfg,
  input  logic              sts_clr,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] write_enb,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_sts
);

  if (ADDR_W < addr_bits(NUM_CH)) begin : g_bad_addr_w
    $error("router_sync_n: ADDR_W too narrow to address NUM_CH channels");
  end

  // One extra bit so NUM_CH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] NumChL = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_q;
  logic              addr_vld_q;
  logic              addr_err_q;
  logic              in_range;

  assign in_range = ({1'b0, data_in} < NumChL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_vld_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else if (detect_add) begin
      addr_q     <= data_in;
      addr_vld_q <= in_range;
      addr_err_q <= ~in_range;
    end
  end

  assign addr_err = addr_err_q;

  // Decode from the registered address; a write in the detect_add cycle
  // still goes to the previous destination.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (addr_vld_q && (addr_q == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
    router_sync_timer #(
      .CNT_W(CNT_W)
    ) u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .vld       (vld_out[g]),
      .rd        (read_enb[g]),
      .cfg       (timeout_cfg),
      .clr       (sts_clr),
      .soft_reset(soft_reset[g]),
      .sts       (timeout_sts[g])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
module tb_router_sync_n;

  logic       clk;
  logic       resetn;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] full;
  logic [2:0] empty;
  logic [2:0] read_enb;
  logic [4:0] timeout_cfg;
  logic       sts_clr;
  logic       fifo_full;
  logic [2:0] write_enb;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       addr_err;
  logic [2:0] timeout_sts;

  int n_pass;
  int n_total;
  int first_t;
  int second_t;
  int highs;

  router_sync_n #(
    .NUM_CH(3),
    .ADDR_W(2),
    .CNT_W (5)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .full         (full),
    .empty        (empty),
    .read_enb     (read_enb),
    .timeout_cfg  (timeout_cfg),
    .sts_clr      (sts_clr),
    .fifo_full    (fifo_full),
    .write_enb    (write_enb),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset),
    .addr_err     (addr_err),
    .timeout_sts  (timeout_sts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Ticks n cycles, recording when soft_reset[ch] is high.
  task automatic watch(input int n, input int ch);
    first_t  = -1;
    second_t = -1;
    highs    = 0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (soft_reset[ch]) begin
        highs++;
        if (first_t < 0) first_t = t;
        else if (second_t < 0) second_t = t;
      end
    end
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    resetn = 1'b0;
    detect_add = 1'b0;
    data_in = 2'd0;
    write_enb_reg = 1'b0;
    full = 3'b000;
    empty = 3'b101;
    read_enb = 3'b000;
    timeout_cfg = 5'd0;
    sts_clr = 1'b0;

    // 1. reset state
    #3;
    chk("rst_vld_out", 32'(vld_out), 'h2);
    chk("rst_soft_reset", 32'(soft_reset), 'h0);
    chk("rst_write_enb", 32'(write_enb), 'h0);
    chk("rst_addr_err", 32'(addr_err), 'h0);
    chk("rst_timeout_sts", 32'(timeout_sts), 'h0);
    tick();
    resetn = 1'b1;
    tick();
    tick();
    chk("post_rst_vld_out", 32'(vld_out), 'h2);
    chk("post_rst_soft_reset", 32'(soft_reset), 'h0);
    chk("post_rst_addr_err", 32'(addr_err), 'h0);

    // 2. address latch and steering
    empty = 3'b111;
    detect_add = 1'b1;
    data_in = 2'd1;
    tick();
    data_in = 2'd2;
    write_enb_reg = 1'b1;
    full = 3'b100;
    #1;
    chk("same_cycle_prev_addr_we", 32'(write_enb), 'h2);
    chk("same_cycle_prev_addr_full", 32'(fifo_full), 'h0);
    tick();
    detect_add = 1'b0;
    #1;
    chk("addr2_write_enb", 32'(write_enb), 'h4);
    chk("addr2_fifo_full", 32'(fifo_full), 'h1);
    chk("addr2_addr_err", 32'(addr_err), 'h0);

    // 3. invalid address
    detect_add = 1'b1;
    data_in = 2'd3;
    full = 3'b111;
    #1;
    chk("bad_addr_same_cycle_we", 32'(write_enb), 'h4);
    tick();
    detect_add = 1'b0;
    #1;
    chk("bad_addr_err", 32'(addr_err), 'h1);
    chk("bad_addr_write_enb", 32'(write_enb), 'h0);
    chk("bad_addr_fifo_full", 32'(fifo_full), 'h0);
    detect_add = 1'b1;
    data_in = 2'd0;
    tick();
    detect_add = 1'b0;
    full = 3'b001;
    #1;
    chk("addr0_err_cleared", 32'(addr_err), 'h0);
    chk("addr0_write_enb", 32'(write_enb), 'h1);
    chk("addr0_fifo_full", 32'(fifo_full), 'h1);

    // 4. timeout 30 on channel 0
    write_enb_reg = 1'b0;
    full = 3'b000;
    timeout_cfg = 5'd30;
    empty = 3'b110;
    watch(61, 0);
    chk("to30_first_pulse", 32'(first_t), 30);
    chk("to30_second_pulse", 32'(second_t), 61);
    chk("to30_pulse_width", 32'(highs), 2);
    chk("to30_sts", 32'(timeout_sts), 'h1);
    sts_clr = 1'b1;
    tick();
    sts_clr = 1'b0;
    chk("to30_sts_cleared", 32'(timeout_sts), 'h0);
    chk("to30_pulse_ended", 32'(soft_reset), 'h0);
    watch(28, 0);
    read_enb = 3'b001;
    tick();
    read_enb = 3'b000;
    if (soft_reset[0]) highs++;
    watch(3, 0);
    chk("to30_read_at_29_no_pulse", 32'(highs), 0);
    chk("to30_read_at_29_sts", 32'(timeout_sts), 'h0);

    // 5. disabled timeout, then enabled mid-run on channel 1
    empty = 3'b101;
    timeout_cfg = 5'd0;
    watch(100, 1);
    chk("disabled_no_pulse", 32'(highs), 0);
    timeout_cfg = 5'd4;
    watch(6, 1);
    chk("cfg4_first_pulse", 32'(first_t), 4);
    chk("cfg4_pulse_count", 32'(highs), 1);
    chk("cfg4_sts", 32'(timeout_sts), 'h2);

    // 6. two channels, set beats clear, async reset mid-count
    sts_clr = 1'b1;
    empty = 3'b111;
    timeout_cfg = 5'd5;
    tick();
    sts_clr = 1'b0;
    chk("ch02_sts_pre", 32'(timeout_sts), 'h0);
    empty = 3'b010;
    watch(4, 0);
    chk("ch02_no_early_pulse", 32'(highs), 0);
    sts_clr = 1'b1;
    tick();
    chk("ch02_soft_reset", 32'(soft_reset), 'h5);
    chk("ch02_set_beats_clear", 32'(timeout_sts), 'h5);
    tick();
    sts_clr = 1'b0;
    chk("ch02_sts_clear_next", 32'(timeout_sts), 'h0);
    chk("ch02_pulse_one_cycle", 32'(soft_reset), 'h0);
    detect_add = 1'b1;
    data_in = 2'd3;
    tick();
    detect_add = 1'b0;
    tick();
    chk("pre_rst_addr_err", 32'(addr_err), 'h1);
    resetn = 1'b0;
    write_enb_reg = 1'b1;
    #1;
    chk("mid_rst_addr_err", 32'(addr_err), 'h0);
    chk("mid_rst_soft_reset", 32'(soft_reset), 'h0);
    chk("mid_rst_write_enb", 32'(write_enb), 'h0);
    chk("mid_rst_vld_out", 32'(vld_out), 'h5);
    tick();
    resetn = 1'b1;
    write_enb_reg = 1'b0;
    // Count restarted from zero: pulse lands exactly 5 edges later.
    watch(6, 2);
    chk("post_rst_count_restart", 32'(first_t), 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
Parametrised address/flow-control synchroniser for an N-output packet router. It sits between the input-side router FSM/register stage and NUM_CH output FIFOs. It latches the destination address on header detect and steers the write enable to one FIFO. It reports the addressed FIFO's full status and per-channel valid. It issues a one-cycle soft reset to any FIFO whose data sits unread for a programmable number of cycles. New over the fixed 3-channel generation: configurable channel count, runtime timeout (including disable), registered address with invalid-address detection, decoded per-channel write enables, and sticky timeout status.

Parameters:
NUM_CH, 3, number of output channels/FIFOs (2..16)
ADDR_W, 2, width of data_in address field; must satisfy 2**ADDR_W >= NUM_CH
CNT_W, 5, width of timeout counter and timeout_cfg

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous, active-low reset
detect_add  in  1  header present; latch address this cycle
data_in  in  ADDR_W  destination address field of header
write_enb_reg  in  1  write request from router FSM
full  in  NUM_CH  per-FIFO full
empty  in  NUM_CH  per-FIFO empty
read_enb  in  NUM_CH  per-FIFO read enable from output side
timeout_cfg  in  CNT_W  idle cycles before soft reset; 0 disables timeout
sts_clr  in  1  clears timeout_sts
fifo_full  out  1  full flag of currently addressed FIFO
write_enb  out  NUM_CH  one-hot decoded write enable
vld_out  out  NUM_CH  per-channel data-valid to output side
soft_reset  out  NUM_CH  one-cycle FIFO flush pulse
addr_err  out  1  latched address is >= NUM_CH
timeout_sts  out  NUM_CH  sticky: channel has issued a soft reset

Behaviour:
- Reset (asynchronous, resetn low): addr_q=0, addr_vld_q=0, addr_err=0, all cnt=0, soft_reset=0, timeout_sts=0. Combinational outputs follow inputs through reset, e.g. vld_out=~empty.
- Address latch: at a clk edge with detect_add=1, addr_q<=data_in and addr_vld_q<=(data_in<NUM_CH). Otherwise both hold.
- addr_err is registered. At a detect_add edge it becomes ~(data_in<NUM_CH). It holds until the next detect_add. Latency is 1 cycle from detect_add.
- Write steering (combinational): write_enb[i] = write_enb_reg & addr_vld_q & (addr_q==i).
  - Uses the registered address, so write_enb_reg in the same cycle as detect_add steers to the previous address.
  - The router FSM issues writes only from the cycle after detect_add.
  - With an invalid address, all write_enb=0 and the packet is dropped.
- fifo_full (combinational) = addr_vld_q ? full[addr_q] : 0.
- vld_out[i] = ~empty[i] (combinational).
- Timeout, per channel i: idle_i = vld_out[i] & ~read_enb[i].
  - If timeout_cfg==0: cnt_i<=0, soft_reset[i]<=0.
  - Else if soft_reset[i]==1: cnt_i<=0, soft_reset[i]<=0 (counting is suppressed during the pulse).
  - Else if idle_i & (cnt_i >= timeout_cfg-1): soft_reset[i]<=1, cnt_i<=0.
  - Else if idle_i: cnt_i<=cnt_i+1, with no wrap past 2**CNT_W-1.
  - Else: cnt_i<=0.
  - Result: soft_reset rises on the edge ending the timeout_cfg-th consecutive idle cycle and lasts exactly 1 cycle.
  - If data is still unread after the pulse, the count restarts and the next pulse comes after timeout_cfg+1 further cycles.
- timeout_cfg changes take effect immediately. The >= compare fires on the next idle cycle if cfg is lowered below the current count.
- Any read_enb or empty cycle clears that channel's count. Channels are fully independent.
- timeout_sts[i]: set on the edge where soft_reset[i] goes 1. Cleared by sts_clr. If set and clear coincide, set wins.

Decomposition:
- Package router_pkg: default NUM_CH, ADDR_W/CNT_W defaults, and a clog2-style helper for ADDR_W validity checks.
- Sub-module router_sync_timer: one channel's cnt, soft_reset and sticky bit. Inputs: vld, rd, cfg, clr. Instantiated NUM_CH times in a generate loop.
- Address latch, decode and full mux stay in the top level.

Test Plan:
1. Reset with empty=3'b101 -> vld_out=3'b010, soft_reset=0, write_enb=0, addr_err=0. After reset release nothing changes.
2. detect_add=1, data_in=2, then write_enb_reg=1, full=3'b100 -> write_enb=3'b100 and fifo_full=1 from the cycle after detect_add. In the detect_add cycle itself, write_enb reflects the previous address.
3. NUM_CH=3, detect_add with data_in=3, then write_enb_reg=1 -> addr_err=1 one cycle later, write_enb=0, fifo_full=0. A subsequent detect_add with data_in=0 clears addr_err.
4. timeout_cfg=30, empty[0]=0, read_enb[0]=0 held -> soft_reset[0] high for exactly 1 cycle after 30 idle cycles, next pulse 31 cycles later, timeout_sts[0]=1. Asserting read_enb[0] at idle cycle 29 -> no pulse.
5. timeout_cfg=0 with channel 1 idle for 100 cycles -> soft_reset[1] never asserts. Setting timeout_cfg=4 mid-run -> pulse after 4 idle cycles.
6. Channels 0 and 2 idle simultaneously with timeout_cfg=5, plus sts_clr asserted on the pulse edge -> both soft_reset pulse in the same cycle and timeout_sts=3'b101 (set beats clear). sts_clr the next cycle -> timeout_sts=0. resetn asserted mid-count -> all counts and outputs return to 0 immediately.
